// File: rtl/am2940_core_if.sv
// Bus bundle for am2940_core: pipeline instruction, data bus, count enable
// and the address / carry / done status lines.
//   master : drives instr, d_in, aci; observes d_out, d_oe, addr, aco, done
//   slave  : the core side
interface am2940_core_if;
  logic [3:0] instr;   // [3] execute, [2:0] opcode
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       aci;
  logic [7:0] addr;
  logic       aco;
  logic       done;

  modport master (output instr, d_in, aci,
                  input  d_out, d_oe, addr, aco, done);
  modport slave  (input  instr, d_in, aci,
                  output d_out, d_oe, addr, aco, done);
endinterface

// File: rtl/am2940_core.sv
// am2940_core: 8-bit DMA address generator (Am2940 style).
// Holds a control register (direction + mode), an address register/counter
// pair and a word-count register/counter pair. ENCT steps both counters and
// raises a sticky done at the mode's terminal condition.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - am2940_core_if.slave (instr, d_in, aci in; d_out, d_oe, addr, aco, done out)
module am2940_core (
  input  logic           clk,
  input  logic           rst,
  am2940_core_if.slave   bus
);
  localparam logic [2:0] OP_WRCR   = 3'd0;
  localparam logic [2:0] OP_RDCR   = 3'd1;
  localparam logic [2:0] OP_RDWC   = 3'd2;
  localparam logic [2:0] OP_RDAC   = 3'd3;
  localparam logic [2:0] OP_REINIT = 3'd4;
  localparam logic [2:0] OP_LDADDR = 3'd5;
  localparam logic [2:0] OP_LDWC   = 3'd6;
  localparam logic [2:0] OP_ENCT   = 3'd7;

  logic [2:0] cr_q, cr_d;
  logic [7:0] addr_reg_q, addr_reg_d, addr_cnt_q, addr_cnt_d;
  logic [7:0] wc_reg_q, wc_reg_d, wc_cnt_q, wc_cnt_d;
  logic       done_q, done_d;

  // While rst is held the outputs already show the reset state, so every
  // combinational output is built from these masked copies of the state.
  logic [2:0] cr_c;
  logic [7:0] addr_cnt_c, wc_cnt_c;
  logic       done_c;
  assign cr_c       = rst ? 3'd0 : cr_q;
  assign addr_cnt_c = rst ? 8'd0 : addr_cnt_q;
  assign wc_cnt_c   = rst ? 8'd0 : wc_cnt_q;
  assign done_c     = rst ? 1'b0 : done_q;

  logic       step;
  logic [1:0] mode;
  logic [7:0] addr_step, wc_step;
  assign mode      = cr_q[1:0];
  assign step      = (bus.instr == 4'b1111) && bus.aci && !done_c;
  assign addr_step = cr_q[2] ? addr_cnt_q - 8'd1 : addr_cnt_q + 8'd1;

  always_comb begin
    wc_step = wc_cnt_q;
    case (mode)
      2'd0:       wc_step = wc_cnt_q - 8'd1;
      2'd1, 2'd2: wc_step = wc_cnt_q + 8'd1;
      default:    wc_step = wc_cnt_q;
    endcase
  end

  // Read-back path and carry out: zero latency from current state.
  logic [7:0] d_out_c;
  logic       d_oe_c;
  always_comb begin
    d_out_c = 8'd0;
    d_oe_c  = 1'b0;
    if (bus.instr[3]) begin
      case (bus.instr[2:0])
        OP_RDCR: begin d_oe_c = 1'b1; d_out_c = {5'd0, cr_c}; end
        OP_RDWC: begin d_oe_c = 1'b1; d_out_c = wc_cnt_c;     end
        OP_RDAC: begin d_oe_c = 1'b1; d_out_c = addr_cnt_c;   end
        default: ;
      endcase
    end
  end

  assign bus.d_out = d_out_c;
  assign bus.d_oe  = d_oe_c;
  assign bus.aco   = step && (cr_c[2] ? (addr_cnt_c == 8'h00) : (addr_cnt_c == 8'hFF));
  assign bus.addr  = addr_cnt_c;
  assign bus.done  = done_c;

  // Next state.
  always_comb begin
    cr_d       = cr_q;
    addr_reg_d = addr_reg_q;
    addr_cnt_d = addr_cnt_q;
    wc_reg_d   = wc_reg_q;
    wc_cnt_d   = wc_cnt_q;
    done_d     = done_q;
    if (bus.instr[3]) begin
      case (bus.instr[2:0])
        OP_WRCR: begin
          cr_d   = bus.d_in[2:0];
          done_d = 1'b0;
        end
        OP_REINIT: begin
          addr_cnt_d = addr_reg_q;
          wc_cnt_d   = (mode == 2'd2) ? 8'd0 : wc_reg_q;
          done_d     = 1'b0;
        end
        OP_LDADDR: begin
          addr_reg_d = bus.d_in;
          addr_cnt_d = bus.d_in;
          done_d     = 1'b0;
        end
        OP_LDWC: begin
          // Mode 2 counts up from zero toward the loaded count.
          wc_reg_d = bus.d_in;
          wc_cnt_d = (mode == 2'd2) ? 8'd0 : bus.d_in;
          done_d   = 1'b0;
        end
        OP_ENCT: begin
          if (step) begin
            addr_cnt_d = addr_step;
            wc_cnt_d   = wc_step;
            case (mode)
              2'd0:    done_d = (wc_step == 8'd0);
              2'd3:    done_d = (addr_step == wc_reg_q);
              default: done_d = (wc_step == wc_reg_q);
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q       <= 3'd0;
      addr_reg_q <= 8'd0;
      addr_cnt_q <= 8'd0;
      wc_reg_q   <= 8'd0;
      wc_cnt_q   <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      cr_q       <= cr_d;
      addr_reg_q <= addr_reg_d;
      addr_cnt_q <= addr_cnt_d;
      wc_reg_q   <= wc_reg_d;
      wc_cnt_q   <= wc_cnt_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: doc/am2940_core.md
AM2940_CORE -- requirements
Module: am2940_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled only on the rising edge of clk.
REQ-002 Port `clk`: input, 1 bit. Rising-edge clock for all state.
REQ-003 Port `rst`: input, 1 bit. Synchronous, active-high reset.
REQ-004 Port `instr`: input, 4 bits. Registered pipeline instruction from the upstream pipeline register. Bit 3 = execute; bits 2:0 = opcode.
REQ-005 Port `d_in`: input, 8 bits. Data bus in, used by the load opcodes.
REQ-006 Port `d_out`: output, 8 bits. Data bus out, used by the read opcodes.
REQ-007 Port `d_oe`: output, 1 bit. Asserted when d_out is valid.
REQ-008 Port `aci`: input, 1 bit. Count enable (carry in) for the ENCT opcode.
REQ-009 Port `addr`: output, 8 bits. Current address counter.
REQ-010 Port `aco`: output, 1 bit. Address carry/borrow out.
REQ-011 Port `done`: output, 1 bit. Transfer complete.

Function
REQ-012 Internal state SHALL comprise:
- cr[2:0], where cr[2] is the address direction (0 = increment, 1 = decrement) and cr[1:0] is the mode;
- addr_reg[7:0] and addr_cnt[7:0];
- wc_reg[7:0] and wc_cnt[7:0];
- done (registered).
REQ-013 When instr[3]=0, the block SHALL hold all state and drive d_oe=0, d_out=0, aco=0.
REQ-014 When instr[3]=1, the opcode SHALL act as follows:
- 0 WRCR: cr <= d_in[2:0]; done <= 0.
- 1 RDCR: d_out = {5'b0, cr}.
- 2 RDWC: d_out = wc_cnt.
- 3 RDAC: d_out = addr_cnt.
- 4 REINIT: addr_cnt <= addr_reg; wc_cnt <= (mode 2 ? 0 : wc_reg); done <= 0.
- 5 LDADDR: addr_reg and addr_cnt <= d_in; done <= 0.
- 6 LDWC: wc_reg <= d_in; wc_cnt <= (mode 2 ? 0 : d_in); done <= 0.
- 7 ENCT: count step, per REQ-016.
REQ-015 For the read opcodes (1, 2, 3), d_oe and d_out SHALL be combinational from current state with zero latency. For all other opcodes, d_oe=0 and d_out=0.
REQ-016 A step SHALL occur when instr=4'b1111, aci=1 and done=0. A step takes effect at the next rising edge.
REQ-017 On a step, addr_cnt SHALL increment (cr[2]=0) or decrement (cr[2]=1) modulo 256.
REQ-018 On a step, wc_cnt SHALL be updated by mode:
- mode 0: decrement modulo 256;
- modes 1 and 2: increment modulo 256;
- mode 3: hold.
REQ-019 On a step, done SHALL be set at the same edge when the post-step value meets the terminal condition for the mode:
- mode 0: new wc_cnt == 0;
- modes 1 and 2: new wc_cnt == wc_reg;
- mode 3: new addr_cnt == wc_reg.
REQ-020 done SHALL be sticky. It clears only on WRCR, REINIT, LDADDR, LDWC or rst. While done=1, ENCT SHALL not change any counter.
REQ-021 aco SHALL be combinational and equal to 1 in exactly these cases:
- a step is occurring with cr[2]=0 and addr_cnt == 8'hFF;
- a step is occurring with cr[2]=1 and addr_cnt == 8'h00.
In all other cases aco SHALL be 0.
REQ-022 Mode 0 with a loaded count of 0 SHALL yield 256 steps before done: the counter wraps to FF and reaches 0 on the 256th step.
REQ-023 Mode 1 or 2 with wc_reg equal to the initial wc_cnt SHALL yield 256 steps before done (full wrap).
REQ-024 Any opcode other than ENCT SHALL not step the counters, regardless of aci.
REQ-025 The addr output SHALL equal addr_cnt at all times.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set cr, addr_reg, addr_cnt, wc_reg and wc_cnt to 0, and done to 0. rst SHALL take priority over any instr in that cycle.
REQ-027 While rst=1, outputs SHALL be addr=0 and done=0. d_oe, d_out and aco SHALL follow REQ-013 to REQ-015 and REQ-021 given the reset state.
REQ-028 If rst is asserted mid-transfer, the block SHALL abort the transfer. After reset, ENCT with aci=1 in mode 0 SHALL step wc_cnt from 00 to FF and SHALL not set done.

Verification
REQ-029 Scenario, mode 0 basic transfer:
- Stimulus: WRCR d_in=0; LDADDR 8'h10; LDWC 8'h03; then ENCT with aci=1 for 5 cycles.
- Response: addr steps to 11, 12, 13. done=1 after the 3rd step. addr holds at 13 afterwards, and wc_cnt=0.
REQ-030 Scenario, decrement across 00 with read-back:
- Stimulus: WRCR d_in=3'b100; LDADDR 8'h01; LDWC 8'h05; ENCT aci=1 for 2 steps; then RDAC.
- Response: aco=1 exactly during the 2nd step, when addr_cnt=00. RDAC then returns d_out=8'hFF with d_oe=1.
REQ-031 Scenario, mode 2 counting up:
- Stimulus: WRCR 3'b010; LDWC 8'h04.
- Response: RDWC returns 00. After 4 steps, done=1 and RDWC returns 04.
REQ-032 Scenario, REINIT after done:
- Stimulus: after REQ-029 completes, issue REINIT.
- Response: done=0, addr=10, wc_cnt=03. Three further steps set done again.
REQ-033 Scenario, idle and gated instructions:
- Stimulus: instr[3]=0 with opcode 7 and aci=1.
- Response: no state change, d_oe=0.
- Stimulus: ENCT with aci=0.
- Response: no step.
REQ-034 Scenario, reset mid-transfer:
- Stimulus: assert rst during a mode 0 transfer.
- Response: the next edge yields addr=0, done=0, and RDCR returns 00.
